// File: rtl/vxe_txnreqd_queue_if.sv
// vxe_txnreqd_queue_if: client write-beat handshake and head-of-queue
// handshake toward the transaction path, bundled for the request data queue.
// The master side is the client/downstream pair; the slave side is the queue.
interface vxe_txnreqd_queue_if #(
  parameter int DEPTH_POW2 = 2
);
  logic [63:0]         i_data;
  logic [7:0]          i_ben;
  logic                i_vld;
  logic                o_rdy;
  logic [71:0]         o_req_vec_dat;
  logic                o_vld;
  logic                i_rdy;
  logic [DEPTH_POW2:0] o_count;

  modport master (
    output i_data,
    output i_ben,
    output i_vld,
    output i_rdy,
    input  o_rdy,
    input  o_req_vec_dat,
    input  o_vld,
    input  o_count
  );

  modport slave (
    input  i_data,
    input  i_ben,
    input  i_vld,
    input  i_rdy,
    output o_rdy,
    output o_req_vec_dat,
    output o_vld,
    output o_count
  );
endinterface

// File: rtl/vxe_txnreqd_queue.sv
// vxe_txnreqd_queue: in-order buffer of 72-bit request data vectors
// {ben[7:0], data[63:0]} feeding the request data decoder. The head vector is
// read combinationally from storage so a beat pushed into an empty queue is
// visible the cycle after its push edge. The head is forced to zero whenever
// the queue is empty so the decoder never sees a stale entry.
module vxe_txnreqd_queue #(
  parameter int DEPTH_POW2 = 2
) (
  input logic                    clk,
  input logic                    rst,
  vxe_txnreqd_queue_if.slave     q
);

  localparam int PTR_W = DEPTH_POW2;
  localparam int CNT_W = DEPTH_POW2 + 1;
  localparam int DEPTH = 1 << DEPTH_POW2;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO   = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [71:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             rdy_s;
  logic             vld_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [71:0]      head_s;

  // Handshake qualifiers: a full queue refuses a push even if it pops this cycle
  always_comb begin
    rdy_s  = (!rst) && (count_r != FULL_COUNT);
    vld_s  = (count_r != CNT_ZERO);
    push_s = q.i_vld && rdy_s;
    pop_s  = vld_s && q.i_rdy;
  end

  // Next occupancy: net change of one entry, or none when push and pop coincide
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy state; reset discards all entries without a pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // Entry storage; written only on an accepted beat, never cleared
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {q.i_ben, q.i_data};
    end
  end

  // Head vector, masked to zero while the queue is empty
  always_comb begin
    head_s = 72'h0;
    if (vld_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = 72'h0;
    end
  end

  assign q.o_rdy         = rdy_s;
  assign q.o_vld         = vld_s;
  assign q.o_req_vec_dat = head_s;
  assign q.o_count       = count_r;

endmodule

// File: tb/tb_vxe_txnreqd_queue.sv
// tb_vxe_txnreqd_queue: directed stimulus for the request data queue. A
// queue-based model follows every clock edge and a compare process checks
// all outputs against it on each falling edge; directed literal checks pin
// the model at the points the scenarios call out.
module tb_vxe_txnreqd_queue;

  localparam int DP    = 2;
  localparam int DEPTH = 1 << DP;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   started;

  vxe_txnreqd_queue_if #(.DEPTH_POW2(DP)) qif ();

  vxe_txnreqd_queue #(.DEPTH_POW2(DP)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference occupancy: plain FIFO of stored vectors
  logic [71:0] mq[$];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each active edge using the pre-edge occupancy
  always @(posedge clk) begin
    automatic bit m_rdy = !rst && (mq.size() != DEPTH);
    automatic bit m_vld = (mq.size() != 0);
    if (rst) begin
      mq.delete();
    end else begin
      if (m_vld && qif.i_rdy) void'(mq.pop_front());
      if (qif.i_vld && m_rdy) mq.push_back({qif.i_ben, qif.i_data});
    end
    started = 1'b1;
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (started) begin
      chk("cmp_vld", {71'h0, qif.o_vld}, {71'h0, mq.size() != 0});
      chk("cmp_cnt", {69'h0, qif.o_count}, 72'(mq.size()));
      chk("cmp_rdy", {71'h0, qif.o_rdy}, {71'h0, (!rst) && (mq.size() != DEPTH)});
      chk("cmp_dat", qif.o_req_vec_dat, (mq.size() != 0) ? mq[0] : 72'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [7:0] b);
    qif.i_data = d;
    qif.i_ben  = b;
    qif.i_vld  = 1'b1;
    step();
    qif.i_vld  = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    started      = 1'b0;
    rst          = 1'b1;
    qif.i_data   = 64'h1111_2222_3333_4444;
    qif.i_ben    = 8'hFF;
    qif.i_vld    = 1'b1;
    qif.i_rdy    = 1'b0;

    // Reset held 3 cycles with i_vld asserted: nothing stored
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_rdy", {71'h0, qif.o_rdy}, 72'h0);
      chk("rst_vld", {71'h0, qif.o_vld}, 72'h0);
    end
    rst       = 1'b0;
    qif.i_vld = 1'b0;
    step();
    chk("post_rst_vld", {71'h0, qif.o_vld}, 72'h0);
    chk("post_rst_cnt", {69'h0, qif.o_count}, 72'h0);
    chk("post_rst_dat", qif.o_req_vec_dat, 72'h0);
    chk("post_rst_rdy", {71'h0, qif.o_rdy}, 72'h1);

    // Single beat
    push_beat(64'hDEAD_BEEF_0123_4567, 8'hF0);
    chk("single_vld", {71'h0, qif.o_vld}, 72'h1);
    chk("single_dat", qif.o_req_vec_dat, 72'hF0_DEAD_BEEF_0123_4567);
    chk("single_cnt", {69'h0, qif.o_count}, 72'h1);
    qif.i_rdy = 1'b1;
    step();
    qif.i_rdy = 1'b0;
    chk("single_pop_vld", {71'h0, qif.o_vld}, 72'h0);
    chk("single_pop_dat", qif.o_req_vec_dat, 72'h0);

    // Fill to full, 5th beat held off, one pop, then 5th accepted
    for (int i = 1; i <= 4; i++) push_beat(64'(i), 8'(i));
    chk("full_cnt", {69'h0, qif.o_count}, 72'h4);
    chk("full_rdy", {71'h0, qif.o_rdy}, 72'h0);
    qif.i_data = 64'd5;
    qif.i_ben  = 8'd5;
    qif.i_vld  = 1'b1;
    step();
    chk("full_hold_cnt", {69'h0, qif.o_count}, 72'h4);
    chk("full_hold_head", qif.o_req_vec_dat, {8'h01, 64'd1});
    qif.i_rdy = 1'b1;
    step();
    qif.i_rdy = 1'b0;
    chk("full_pop_cnt", {69'h0, qif.o_count}, 72'h3);
    chk("full_pop_head", qif.o_req_vec_dat, {8'h02, 64'd2});
    step();
    qif.i_vld = 1'b0;
    chk("fifth_cnt", {69'h0, qif.o_count}, 72'h4);
    qif.i_rdy = 1'b1;
    for (int e = 2; e <= 5; e++) begin
      chk("drain_order", qif.o_req_vec_dat, {8'(e), 64'(e)});
      step();
    end
    qif.i_rdy = 1'b0;
    chk("drain_empty_cnt", {69'h0, qif.o_count}, 72'h0);

    // Full with simultaneous push and pop
    for (int i = 10; i <= 13; i++) push_beat(64'(i), 8'(i));
    qif.i_data = 64'd14;
    qif.i_ben  = 8'd14;
    qif.i_vld  = 1'b1;
    qif.i_rdy  = 1'b1;
    step();
    chk("fullpp_cnt", {69'h0, qif.o_count}, 72'h3);
    chk("fullpp_head", qif.o_req_vec_dat, {8'd11, 64'd11});
    step();
    qif.i_vld = 1'b0;
    chk("fullpp2_cnt", {69'h0, qif.o_count}, 72'h3);
    for (int e = 12; e <= 14; e++) begin
      chk("fullpp_drain", qif.o_req_vec_dat, {8'(e), 64'(e)});
      step();
    end
    qif.i_rdy = 1'b0;

    // Streaming through pointer wrap
    qif.i_rdy = 1'b1;
    qif.i_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      qif.i_data = 64'(i);
      qif.i_ben  = 8'(i);
      step();
      chk("stream_head", qif.o_req_vec_dat, {8'(i), 64'(i)});
      chk("stream_cnt", {69'h0, qif.o_count}, 72'h1);
    end
    qif.i_vld = 1'b0;
    step();
    qif.i_rdy = 1'b0;
    chk("stream_end_cnt", {69'h0, qif.o_count}, 72'h0);

    // Reset mid-operation
    for (int i = 20; i <= 22; i++) push_beat(64'(i), 8'(i));
    chk("mid_pre_cnt", {69'h0, qif.o_count}, 72'h3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_cnt", {69'h0, qif.o_count}, 72'h0);
    chk("mid_rst_vld", {71'h0, qif.o_vld}, 72'h0);
    push_beat(64'h99, 8'hAA);
    chk("mid_first_out", qif.o_req_vec_dat, {8'hAA, 64'h99});
    qif.i_rdy = 1'b1;
    step();
    qif.i_rdy = 1'b0;
    chk("mid_final_cnt", {69'h0, qif.o_count}, 72'h0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
